cordic_vectoring: RTL and testbench
===================================

Name: cordic_vectoring

Overview:
- Pipelined vectoring-mode CORDIC; the inverse of the rotation-mode sine/cosine generator.
- Takes a signed 16-bit (X,Y) sample and returns its phase and its unscaled magnitude.
- Phase uses the same 16-bit convention as the generator's phase accumulator: full circle = 2^16, 90° = 0x4000, 180° = 0x8000, 270° = 0xC000.
- Used to recover phase from generated or received I/Q for loopback checking and phase detection.
- Fully pipelined, one sample per clock, no backpressure.

Parameters:
- STAGES, 16, number of CORDIC micro-rotation stages (legal 8..16).

Ports:
- Clk_i    input   1   clock, all logic on rising edge
- Rst_i    input   1   synchronous, active-high reset
- X_i      input   16  signed in-phase component
- Y_i      input   16  signed quadrature component
- Valid_i  input   1   X_i/Y_i valid this cycle
- Angle_o  output  16  unsigned phase, 2^16 = 360°
- Mag_o    output  17  unsigned magnitude times CORDIC gain K ≈ 1.64676
- Valid_o  output  1   Angle_o/Mag_o valid this cycle

Behaviour:
- Reset: while Rst_i = 1 at a clock edge, clear Angle_o, Mag_o, Valid_o and every pipeline valid/zero flag to 0. Data registers other than the outputs need no reset.
- Latency: exactly STAGES+2 cycles from Valid_i to Valid_o. Stage P is pre-rotation, then STAGES iteration stages, then the output register. Throughput is 1 per cycle.
- Valid pipelining:
  - Valid_i is carried down the pipe unconditionally.
  - Data with Valid_i = 0 may flow through, but Valid_o must be 0 for it.
  - Angle_o/Mag_o update every cycle. They are only meaningful when Valid_o = 1.
- Stage P (pre-rotation), all internal x/y are 19-bit signed:
  - If X_i < 0: x0 = -X_i, y0 = -Y_i, z0 = 0x8000.
  - Otherwise: x0 = X_i, y0 = Y_i, z0 = 0x0000.
  - Sign-extend X_i/Y_i before negating, so -(-32768) = +32768 with no overflow.
  - Zero flag zf = (X_i == 0 && Y_i == 0), pipelined alongside valid.
- Stage i (i = 0..STAGES-1), using arithmetic shifts:
  - If y >= 0: x' = x + (y>>>i), y' = y - (x>>>i), z' = z + A[i].
  - Otherwise: x' = x - (y>>>i), y' = y + (x>>>i), z' = z - A[i].
  - z is 16-bit and wraps modulo 2^16. Wrap is intentional and provides the 360° wrap, e.g. 0x0000 - small = 0xFFFx.
- Angle table: A[i] = round(atan(2^-i) · 65536 / 2π), as constants.
  - 0:8192, 1:4836, 2:2555, 3:1297, 4:651, 5:326, 6:163, 7:81
  - 8:41, 9:20, 10:10, 11:5, 12:3, 13:1, 14:1, 15:0
- Output register:
  - Angle_o = z_final. Mag_o = x_final[16:0]; x_final is always >= 0 and < 2^17.
  - If the pipelined zf = 1, force Angle_o = 0 and Mag_o = 0. This gives a deterministic atan2(0,0).
- Accuracy at STAGES = 16:
  - |Angle_o - ideal| <= 4 LSB (mod 2^16).
  - |Mag_o - K·sqrt(X²+Y²)| <= 4 + 0.0005·ideal.
  - Worst-case magnitude for input (-32768,-32768) is ≈ 76314, which must not overflow.
- Boundary inputs:
  - X = 0, Y > 0 gives 0x4000. X = 0, Y < 0 gives 0xC000.
  - X < 0, Y = 0 gives ≈0x8000, either side within tolerance.
- Reset mid-stream: samples in flight are discarded. Valid_o stays 0 until STAGES+2 cycles after the first post-reset Valid_i.

Test Plan:
- Axis points, STAGES = 16, single Valid_i pulses:
  - (1000,0) -> Angle 0x0000±4, Mag 1647±4.
  - (0,1000) -> 0x4000±4, Mag 1647±4.
  - (-1000,0) -> 0x8000±4, Mag 1647±4.
  - (0,-1000) -> 0xC000±4, Mag 1647±4.
  - Valid_o asserts exactly 18 cycles after each Valid_i.
- Diagonals:
  - (1000,1000) -> 0x2000±4, Mag 2329±4.
  - (-32768,-32768) -> 0xA000±4, Mag 76314±40, no wrap.
  - (32767,-32768) -> ≈0xE000±4.
- Zero input (0,0) with Valid_i = 1 -> Valid_o = 1 with Angle_o = 0, Mag_o = 0.
- Loopback sweep:
  - Drive the sine/cosine generator output (Cos,Sin) into X_i/Y_i for 1024 consecutive samples with Valid_i held high.
  - Angle_o must track the generator phase, compensated for latency, within ±8 LSB.
  - Valid_o must be high every cycle with no bubbles after fill.
- Valid gaps: alternate Valid_i 1/0 with random data -> Valid_o reproduces the same 1/0 pattern delayed 18 cycles, and values match the reference model.
- Reset mid-stream: assert Rst_i for 1 cycle while 10 samples are in flight -> Valid_o = 0, Angle_o = 0, Mag_o = 0 next cycle, and no stale sample emerges afterwards.

Source files
------------

// File: rtl/cordic_vectoring_if.sv
// cordic_vectoring_if: sample input and phase/magnitude result bundle for the vectoring CORDIC.
interface cordic_vectoring_if;
    logic signed [15:0] X_i;
    logic signed [15:0] Y_i;
    logic               Valid_i;
    logic        [15:0] Angle_o;
    logic        [16:0] Mag_o;
    logic               Valid_o;

    modport master (output X_i, Y_i, Valid_i, input Angle_o, Mag_o, Valid_o);
    modport slave (input X_i, Y_i, Valid_i, output Angle_o, Mag_o, Valid_o);
endinterface

// File: rtl/cordic_vectoring.sv
// cordic_vectoring: pipelined vectoring-mode CORDIC returning the 16-bit phase and
// gain-scaled magnitude of a signed (X,Y) sample, one sample per clock.
module cordic_vectoring #(
    parameter int STAGES = 16
) (
    input logic Clk_i,
    input logic Rst_i,
    cordic_vectoring_if.slave bus
);
    localparam logic [15:0] ATAN [16] = '{
        16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326, 16'd163, 16'd81,
        16'd41,   16'd20,   16'd10,   16'd5,    16'd3,   16'd1,   16'd1,   16'd0
    };

    logic signed [18:0] x_d [0:STAGES];
    logic signed [18:0] x_q [0:STAGES];
    logic signed [18:0] y_d [0:STAGES];
    logic signed [18:0] y_q [0:STAGES];
    logic        [15:0] z_d [0:STAGES];
    logic        [15:0] z_q [0:STAGES];
    logic [STAGES:0]    v_d, v_q, zf_d, zf_q;
    logic [15:0]        angle_d, angle_q;
    logic [16:0]        mag_d, mag_q;
    logic               valid_d, valid_q;
    logic signed [18:0] xs, ys;

    always_comb begin
        xs = {{3{bus.X_i[15]}}, bus.X_i};
        ys = {{3{bus.Y_i[15]}}, bus.Y_i};
        // left half-plane is folded onto the right by a 180 degree pre-rotation
        x_d[0] = xs[18] ? -xs : xs;
        y_d[0] = xs[18] ? -ys : ys;
        z_d[0] = xs[18] ? 16'h8000 : 16'h0000;
        v_d = {v_q[STAGES-1:0], bus.Valid_i};
        zf_d = {zf_q[STAGES-1:0], (bus.X_i == 16'sd0) && (bus.Y_i == 16'sd0)};
        for (int i = 0; i < STAGES; i++) begin
            x_d[i+1] = y_q[i][18] ? x_q[i] - (y_q[i] >>> i) : x_q[i] + (y_q[i] >>> i);
            y_d[i+1] = y_q[i][18] ? y_q[i] + (x_q[i] >>> i) : y_q[i] - (x_q[i] >>> i);
            z_d[i+1] = y_q[i][18] ? z_q[i] - ATAN[i] : z_q[i] + ATAN[i];
        end
        angle_d = zf_q[STAGES] ? 16'h0000 : z_q[STAGES];
        mag_d = zf_q[STAGES] ? 17'h00000 : 17'(x_q[STAGES]);
        valid_d = v_q[STAGES];
    end

    always_ff @(posedge Clk_i) begin
        x_q <= x_d;
        y_q <= y_d;
        z_q <= z_d;
        v_q <= Rst_i ? '0 : v_d;
        zf_q <= Rst_i ? '0 : zf_d;
        angle_q <= Rst_i ? '0 : angle_d;
        mag_q <= Rst_i ? '0 : mag_d;
        valid_q <= Rst_i ? 1'b0 : valid_d;
    end

    assign bus.Angle_o = angle_q;
    assign bus.Mag_o = mag_q;
    assign bus.Valid_o = valid_q;
endmodule

// File: tb/tb_cordic_vectoring.sv
// tb_cordic_vectoring: directed and randomized checks of the vectoring CORDIC against
// an arithmetic model of the algorithm plus an ideal-phase tracking check.
module tb_cordic_vectoring;
    localparam int LAT = 18;
    localparam int ATAN [16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81,
                                 41, 20, 10, 5, 3, 1, 1, 0};
    localparam real PI = 3.14159265358979323846;

    typedef struct packed {
        bit v;
        bit lb;
        int a;
        int m;
        int ph;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int failures = 0;
    exp_t pipe[$];

    cordic_vectoring_if bus();
    cordic_vectoring #(.STAGES(16)) dut (.Clk_i(clk), .Rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic exp_t model(int x, int y, bit v, bit lb, int ph);
        exp_t e;
        int xi, yi, xn, z;
        e.v = v;
        e.lb = lb;
        e.ph = ph;
        e.a = 0;
        e.m = 0;
        if (x == 0 && y == 0) return e;
        xi = x < 0 ? -x : x;
        yi = x < 0 ? -y : y;
        z = x < 0 ? 32768 : 0;
        for (int i = 0; i < 16; i++) begin
            if (yi >= 0) begin
                xn = xi + (yi >>> i);
                yi = yi - (xi >>> i);
                z = z + ATAN[i];
            end else begin
                xn = xi - (yi >>> i);
                yi = yi + (xi >>> i);
                z = z - ATAN[i];
            end
            xi = xn;
        end
        e.a = z & 32'hFFFF;
        e.m = xi;
        return e;
    endfunction

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_phase(int obs, int ph);
        int d;
        d = (obs - ph) & 32'hFFFF;
        if (d >= 32768) d = d - 65536;
        checks++;
        assert (d <= 8 && d >= -8) else begin
            failures++;
            $error("FAIL phase observed=%0d expected=%0d(+-8)", obs, ph);
        end
    endtask

    task automatic step(bit v, int x, int y, bit lb = 1'b0, int ph = 0);
        exp_t e;
        @(negedge clk);
        bus.Valid_i = v;
        bus.X_i = 16'(x);
        bus.Y_i = 16'(y);
        pipe.push_back(model(x, y, v, lb, ph));
        @(posedge clk);
        #1;
        if (pipe.size() == LAT) begin
            e = pipe.pop_front();
            chk("valid", int'(bus.Valid_o), int'(e.v));
            if (e.v) begin
                chk("angle", int'(bus.Angle_o), e.a);
                chk("mag", int'(bus.Mag_o), e.m);
                if (e.lb) chk_phase(int'(bus.Angle_o), e.ph);
            end
        end else begin
            chk("fill_valid", int'(bus.Valid_o), 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.Valid_i = 1'b1;
        bus.X_i = 16'($urandom);
        bus.Y_i = 16'($urandom);
        @(posedge clk);
        #1;
        chk("rst_valid", int'(bus.Valid_o), 0);
        chk("rst_angle", int'(bus.Angle_o), 0);
        chk("rst_mag", int'(bus.Mag_o), 0);
        pipe.delete();
        rst = 1'b0;
        bus.Valid_i = 1'b0;
    endtask

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    initial begin
        int dx [10] = '{1000, 0, -1000, 0, 1000, -32768, 32767, 0, -5, 0};
        int dy [10] = '{0, 1000, 0, -1000, 1000, -32768, -32768, 0, 0, -32768};
        rst = 1'b1;
        bus.Valid_i = 1'b0;
        bus.X_i = '0;
        bus.Y_i = '0;
        repeat (3) @(posedge clk);
        do_reset();

        // isolated pulses: axes, diagonals, extreme corner and zero input
        for (int k = 0; k < 10; k++) begin
            step(1'b1, dx[k], dy[k]);
            repeat (LAT + 1) step(1'b0, rnd16(), rnd16());
        end

        // loopback sweep from an ideal sine/cosine source, valid held high
        for (int k = 0; k < 1024; k++) begin
            int ph, x, y;
            ph = (k * 64 + 13) & 32'hFFFF;
            x = int'(30000.0 * $cos(2.0 * PI * real'(ph) / 65536.0));
            y = int'(30000.0 * $sin(2.0 * PI * real'(ph) / 65536.0));
            step(1'b1, x, y, 1'b1, ph);
        end
        repeat (LAT) step(1'b0, 0, 0);

        // alternating valid with random data
        for (int k = 0; k < 80; k++) step(k % 2 == 0, rnd16(), rnd16());
        repeat (LAT) step(1'b0, rnd16(), rnd16());

        // reset with samples in flight: nothing stale may emerge
        repeat (10) step(1'b1, rnd16(), rnd16());
        do_reset();
        repeat (LAT + 8) step(1'b0, rnd16(), rnd16());
        for (int k = 0; k < 40; k++) step(($urandom & 1) == 1, rnd16(), rnd16());
        repeat (LAT) step(1'b0, rnd16(), rnd16());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
